noc_switch_allocator: RTL

Per-output-port switch allocator for the 5-port mesh router. Takes the head-flit state of each input buffer (flit type and the one-hot route produced by the per-input route-compute units). For each output port it grants one input by round-robin at packet granularity, then holds that input-to-output lock until the tail flit has passed. It drives the crossbar select lines and the input-buffer pop strobes.

---
 rtl/noc_router_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/noc_switch_allocator.sv | 115 +++++++++++
 3 files changed

// File: rtl/noc_router_pkg.sv
// Shared router constants: port indices, flit types and allocator state encoding.
package noc_router_pkg;

  localparam int unsigned P  = 5;
  localparam int unsigned PW = 3;

  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_N = 4;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HDR    = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Port index increment wrapping P-1 -> 0.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
    return (x == PW'(P - 1)) ? '0 : x + PW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
  import noc_router_pkg::*;
(
  input  logic [P-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [P-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW:0] cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < P; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(P)) cand = cand - (PW+1)'(P);
      if (!found && req[cand[PW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[PW-1:0]]    = 1'b1;
        idx                  = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Per-output switch allocator: packet-granular round-robin grant, lock held until tail.
module noc_switch_allocator
  import noc_router_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [P-1:0]    in_valid,
  input  logic [2*P-1:0]  in_type,
  input  logic [P*P-1:0]  in_route,
  input  logic [P-1:0]    out_ready,
  output logic [P-1:0]    in_grant,
  output logic [P-1:0]    out_valid,
  output logic [P*PW-1:0] out_sel
);

  logic [P-1:0]   is_hdr;
  logic [P-1:0]   owned;
  logic [P-1:0]   locked;
  logic [P*P-1:0] route_low;
  logic [P*P-1:0] grant_flat;

  // Multi-hot routes collapse to their lowest set bit; zero stays zero.
  always_comb begin
    route_low = '0;
    for (int unsigned i = 0; i < P; i++)
      route_low[P*i +: P] = in_route[P*i +: P] & (~in_route[P*i +: P] + P'(1));
  end

  always_comb begin
    is_hdr = '0;
    for (int unsigned i = 0; i < P; i++)
      is_hdr[i] = in_valid[i] & in_type[2*i+1];
  end

  always_comb begin
    owned = '0;
    for (int unsigned o = 0; o < P; o++)
      if (locked[o]) owned[out_sel[PW*o +: PW]] = 1'b1;
  end

  always_comb begin
    in_grant = '0;
    for (int unsigned o = 0; o < P; o++)
      in_grant = in_grant | grant_flat[P*o +: P];
  end

  for (genvar o = 0; o < P; o++) begin : g_out
    alloc_state_e   state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [PW-1:0]  rr_q, rr_d;
    logic [PW-1:0]  arb_idx;
    logic [P-1:0]   req, arb_gnt, gnt;
    logic           xfer;

    always_comb begin
      req = '0;
      for (int unsigned i = 0; i < P; i++)
        req[i] = is_hdr[i] & ~owned[i] & route_low[P*i+o];
    end

    rr_arbiter u_arb (
      .req (req),
      .ptr (rr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
    );

    assign xfer = (state_q == LOCKED) & in_valid[owner_q] & out_ready[o];

    always_comb begin
      gnt = '0;
      if (xfer) gnt[owner_q] = 1'b1;
    end

    // Low type bit marks tail or single-flit: the packet ends with this transfer.
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            owner_d = arb_idx;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && in_type[{owner_q, 1'b0}]) begin
            state_d = IDLE;
            rr_d    = next_idx(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        owner_q <= '0;
        rr_q    <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        rr_q    <= rr_d;
      end
    end

    assign locked[o]             = (state_q == LOCKED);
    assign out_valid[o]          = xfer;
    assign out_sel[PW*o +: PW]   = owner_q;
    assign grant_flat[P*o +: P]  = gnt;
  end

endmodule
